// File: rtl/execute_mem_pipe_pkg.sv
// Shared types and encodings for the load/store execution unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: access-size encodings, default unit code, the writeback-stage
// record carried by M1 and the delay stages, and two small decode helpers.
package mem_pkg;

  localparam int MEM_DATA_W = 32;

  // Access sizes; the unused code 2'd3 decodes as a word everywhere.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] FU_ID_MEM = 2'd2;

  typedef struct packed {
    logic                  valid;
    logic [4:0]            regdest;
    logic                  writereg;
    logic [MEM_DATA_W-1:0] wbvalue;
    logic                  fault;
  } stage_t;

  // Natural alignment: halves on even bytes, words on word boundaries.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

  // Byte lanes touched by an aligned access at byte offset off.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/execute_mem_pipe_if.sv
// Issue-to-unit and unit-to-writeback signal bundle.
// Latency: n/a (wiring only).
// Backpressure: none; issue pushes one slot per cycle, writeback always accepts.
//
// master: the issue/writeback side (drives is_m0_*, observes m_wb_*).
// slave : the execution unit (observes is_m0_*, drives m_wb_*).
interface execute_mem_pipe_if #(
  parameter int DATA_W = 32
);
  logic [1:0]        is_m0_functionalunit;
  logic              is_m0_readmem;
  logic              is_m0_writemem;
  logic [1:0]        is_m0_size;
  logic              is_m0_signext;
  logic [DATA_W-1:0] is_m0_rega;
  logic [DATA_W-1:0] is_m0_imedext;
  logic [DATA_W-1:0] is_m0_regdestv;
  logic [4:0]        is_m0_regdest;
  logic              is_m0_writereg;

  logic              m_wb_valid;
  logic [4:0]        m_wb_regdest;
  logic              m_wb_writereg;
  logic [DATA_W-1:0] m_wb_wbvalue;
  logic              m_wb_fault;

  modport master (
    output is_m0_functionalunit, is_m0_readmem, is_m0_writemem, is_m0_size,
           is_m0_signext, is_m0_rega, is_m0_imedext, is_m0_regdestv,
           is_m0_regdest, is_m0_writereg,
    input  m_wb_valid, m_wb_regdest, m_wb_writereg, m_wb_wbvalue, m_wb_fault
  );

  modport slave (
    input  is_m0_functionalunit, is_m0_readmem, is_m0_writemem, is_m0_size,
           is_m0_signext, is_m0_rega, is_m0_imedext, is_m0_regdestv,
           is_m0_regdest, is_m0_writereg,
    output m_wb_valid, m_wb_regdest, m_wb_writereg, m_wb_wbvalue, m_wb_fault
  );

endinterface

// File: rtl/execute_mem_pipe_ram.sv
// Data memory: 2^ADDR_W x 32 words, async read, byte-enabled sync write.
// Latency: read combinational; write lands on the rising clock edge.
// Backpressure: none; one read and one write per cycle to the same index.
//
// Ports: clock, reset (async active-low, clears every word), idx (word index
// shared by read and write), rd_dat, wr_en, wr_be (per-byte enables), wr_dat.
module mem_ram #(
  parameter int ADDR_W = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] idx,
  output logic [31:0]       rd_dat,
  input  logic              wr_en,
  input  logic [3:0]        wr_be,
  input  logic [31:0]       wr_dat
);

  localparam int WORDS = 1 << ADDR_W;

  logic [31:0] mem [WORDS];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem[idx][b*8 +: 8] <= wr_dat[b*8 +: 8];
        end
      end
    end
  end

  assign rd_dat = mem[idx];

endmodule

// File: rtl/execute_mem_pipe.sv
// Load/store execution unit: address calc, aligned byte/half/word access, delay to writeback.
// Latency: slot presented before edge k shows on m_wb_* after edge k+DEPTH-1.
// Backpressure: none; accepts one slot per cycle and never stalls.
//
// Ports: clock, reset (async active-low), bus (execute_mem_pipe_if.slave):
//   is_m0_* issue slot in, m_wb_* writeback record out.
// Stages: M0 register (decoded slot) -> M1 (RAM access, M1 output register)
//   -> DEPTH-2 delay registers -> writeback.
module execute_mem_pipe
  import mem_pkg::*;
#(
  parameter int         DATA_W = 32,
  parameter int         ADDR_W = 7,
  parameter int         DEPTH  = 4,
  parameter logic [1:0] FU_ID  = FU_ID_MEM
) (
  input  logic               clock,
  input  logic               reset,
  execute_mem_pipe_if.slave  bus
);

  // Decoded slot held during its M1 cycle. load/store already have the
  // misalignment and load-vs-store priority folded in.
  typedef struct packed {
    logic              vld;
    logic              load;
    logic              store;
    logic [1:0]        size;
    logic              sext;
    logic [1:0]        off;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] sdat;
    logic [4:0]        regdest;
    logic              writereg;
    logic              fault;
  } m0_t;

  // ---------------------------------------------------------------------------
  // M0: select, address, misalignment
  // ---------------------------------------------------------------------------
  logic              sel;
  logic [ADDR_W+1:0] addr;
  logic              mis;
  m0_t               m0_n;
  m0_t               m0_q;

  assign sel = (bus.is_m0_functionalunit == FU_ID);

  // Only the word-index and offset bits matter; the carry out of them cannot
  // reach them, so the narrow sum equals the full sum modulo memory size.
  assign addr = bus.is_m0_rega[ADDR_W+1:0] + bus.is_m0_imedext[ADDR_W+1:0];

  // Misalignment only means something for an actual memory access.
  assign mis = (bus.is_m0_readmem | bus.is_m0_writemem) &
               is_misaligned(bus.is_m0_size, addr[1:0]);

  always_comb begin
    m0_n = '0;
    if (sel) begin
      m0_n.vld      = 1'b1;
      m0_n.store    = bus.is_m0_writemem & ~mis;
      // A slot flagged as both load and store executes as a store only.
      m0_n.load     = bus.is_m0_readmem & ~bus.is_m0_writemem & ~mis;
      m0_n.size     = bus.is_m0_size;
      m0_n.sext     = bus.is_m0_signext;
      m0_n.off      = addr[1:0];
      m0_n.idx      = addr[ADDR_W+1:2];
      m0_n.sdat     = bus.is_m0_regdestv;
      m0_n.regdest  = bus.is_m0_regdest;
      m0_n.writereg = bus.is_m0_writereg & ~mis;
      m0_n.fault    = mis;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      m0_q <= '0;
    end else begin
      m0_q <= m0_n;
    end
  end

  // ---------------------------------------------------------------------------
  // M1: RAM access. The store commits on the edge that ends M1, so a load in
  // the very next M1 cycle already reads the new word without forwarding.
  // ---------------------------------------------------------------------------
  logic [31:0] rd_word;
  logic [31:0] lane;
  logic [31:0] ld_val;
  logic [31:0] wr_dat;
  logic [3:0]  wr_be;
  logic [4:0]  lane_sh;
  stage_t      m1_n;

  assign lane_sh = {m0_q.off, 3'b000};
  assign wr_be   = byte_en(m0_q.size, m0_q.off);
  assign wr_dat  = 32'(m0_q.sdat) << lane_sh;

  mem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock  (clock),
    .reset  (reset),
    .idx    (m0_q.idx),
    .rd_dat (rd_word),
    .wr_en  (m0_q.store),
    .wr_be  (wr_be),
    .wr_dat (wr_dat)
  );

  // Move the addressed lane down to bit 0, then extend to full width.
  assign lane = rd_word >> lane_sh;

  always_comb begin
    ld_val = '0;
    if (m0_q.load) begin
      case (m0_q.size)
        SZ_BYTE: ld_val = {{24{m0_q.sext & lane[7]}},  lane[7:0]};
        SZ_HALF: ld_val = {{16{m0_q.sext & lane[15]}}, lane[15:0]};
        default: ld_val = lane;
      endcase
    end
  end

  always_comb begin
    m1_n          = '0;
    m1_n.valid    = m0_q.vld;
    m1_n.regdest  = m0_q.regdest;
    m1_n.writereg = m0_q.writereg;
    m1_n.wbvalue  = ld_val;
    m1_n.fault    = m0_q.fault;
  end

  // ---------------------------------------------------------------------------
  // M1 output register plus DEPTH-2 plain delay stages. stg_q[0] is the M1
  // output register; the last element drives writeback.
  // ---------------------------------------------------------------------------
  stage_t stg_q [DEPTH-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stg_q[0] <= '0;
    end else begin
      stg_q[0] <= m1_n;
    end
  end

  for (genvar i = 1; i < DEPTH - 1; i++) begin : g_dly
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        stg_q[i] <= '0;
      end else begin
        stg_q[i] <= stg_q[i-1];
      end
    end
  end

  assign bus.m_wb_valid    = stg_q[DEPTH-2].valid;
  assign bus.m_wb_regdest  = stg_q[DEPTH-2].regdest;
  assign bus.m_wb_writereg = stg_q[DEPTH-2].writereg;
  assign bus.m_wb_wbvalue  = DATA_W'(stg_q[DEPTH-2].wbvalue);
  assign bus.m_wb_fault    = stg_q[DEPTH-2].fault;

endmodule

// File: tb/tb_execute_mem_pipe.sv
// Bench for execute_mem_pipe: three instances (DEPTH 4, 2, 6) share one stimulus.
// Latency: expected records are due DEPTH-1 edges after the capture edge.
// Backpressure: none; a record is pushed for every driven cycle, bubbles included.
module tb_execute_mem_pipe;

  typedef struct {
    int          due;
    logic        vld;
    logic [4:0]  rd;
    logic        wr;
    logic [31:0] val;
    logic        flt;
  } exp_t;

  logic clock;
  logic reset;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  logic [1:0]  t_fu;
  logic        t_rd;
  logic        t_wr;
  logic [1:0]  t_sz;
  logic        t_sx;
  logic [31:0] t_ra;
  logic [31:0] t_imm;
  logic [31:0] t_sv;
  logic [4:0]  t_rdst;
  logic        t_wreg;

  logic        o_vld [3];
  logic [4:0]  o_rd  [3];
  logic        o_wr  [3];
  logic [31:0] o_val [3];
  logic        o_flt [3];

  exp_t        sbq [3][$];
  logic [31:0] mdl [128];

  function automatic int dep_of(input int g);
    return (g == 0) ? 4 : (g == 1) ? 2 : 6;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D = (g == 0) ? 4 : (g == 1) ? 2 : 6;
    execute_mem_pipe_if #(.DATA_W(32)) bus ();
    assign bus.is_m0_functionalunit = t_fu;
    assign bus.is_m0_readmem        = t_rd;
    assign bus.is_m0_writemem       = t_wr;
    assign bus.is_m0_size           = t_sz;
    assign bus.is_m0_signext        = t_sx;
    assign bus.is_m0_rega           = t_ra;
    assign bus.is_m0_imedext        = t_imm;
    assign bus.is_m0_regdestv       = t_sv;
    assign bus.is_m0_regdest        = t_rdst;
    assign bus.is_m0_writereg       = t_wreg;
    assign o_vld[g] = bus.m_wb_valid;
    assign o_rd[g]  = bus.m_wb_regdest;
    assign o_wr[g]  = bus.m_wb_writereg;
    assign o_val[g] = bus.m_wb_wbvalue;
    assign o_flt[g] = bus.m_wb_fault;
    execute_mem_pipe #(
      .DATA_W (32),
      .ADDR_W (7),
      .DEPTH  (D),
      .FU_ID  (2'd2)
    ) u_dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
    );
  end

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic cmp_out(input int g, input exp_t e);
    string t;
    t = $sformatf("d%0d@%0d", dep_of(g), e.due);
    check({t, " valid"},    32'(o_vld[g]), 32'(e.vld));
    check({t, " regdest"},  32'(o_rd[g]),  32'(e.rd));
    check({t, " writereg"}, 32'(o_wr[g]),  32'(e.wr));
    check({t, " wbvalue"},  o_val[g],      e.val);
    check({t, " fault"},    32'(o_flt[g]), 32'(e.flt));
  endtask

  // Scoreboard consumer: compare whatever record falls due this cycle.
  always @(negedge clock) begin : chk
    exp_t e;
    for (int g = 0; g < 3; g++) begin
      if (sbq[g].size() > 0 && sbq[g][0].due == cyc) begin
        e = sbq[g].pop_front();
        cmp_out(g, e);
      end
    end
  end

  // Drive one slot (called just after a rising edge), update the memory model
  // in program order and push the expected writeback record for each depth.
  task automatic issue(input logic [1:0] fu, input logic rd, input logic wr,
                       input logic [1:0] sz, input logic sx, input logic [31:0] ra,
                       input logic [31:0] imm, input logic [31:0] sv,
                       input logic [4:0] rdst, input logic wreg);
    exp_t        e;
    logic [31:0] a;
    logic [31:0] w;
    logic [7:0]  b8;
    logic [15:0] h16;
    logic        sel;
    logic        mis;
    int          o;
    int          idx;
    t_fu = fu; t_rd = rd; t_wr = wr; t_sz = sz; t_sx = sx;
    t_ra = ra; t_imm = imm; t_sv = sv; t_rdst = rdst; t_wreg = wreg;
    a   = ra + imm;
    o   = int'(a[1:0]);
    idx = int'(a[8:2]);
    sel = (fu == 2'd2);
    mis = sel && (rd || wr) && ((sz == 2'd1 && o % 2 == 1) || (sz >= 2'd2 && o != 0));
    e.vld = sel;
    e.rd  = sel ? rdst : 5'd0;
    e.wr  = sel && wreg && !mis;
    e.flt = mis;
    e.val = 32'h0;
    if (sel && !mis && wr) begin
      case (sz)
        2'd0:    mdl[idx][o*8 +: 8]  = sv[7:0];
        2'd1:    mdl[idx][o*8 +: 16] = sv[15:0];
        default: mdl[idx] = sv;
      endcase
    end else if (sel && !mis && rd) begin
      w = mdl[idx];
      case (sz)
        2'd0: begin
          b8 = w[o*8 +: 8];
          e.val = sx ? {{24{b8[7]}}, b8} : {24'h0, b8};
        end
        2'd1: begin
          h16 = w[o*8 +: 16];
          e.val = sx ? {{16{h16[15]}}, h16} : {16'h0, h16};
        end
        default: e.val = w;
      endcase
    end
    for (int g = 0; g < 3; g++) begin
      e.due = cyc + dep_of(g);
      sbq[g].push_back(e);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic bubble();
    issue(2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] v);
    issue(2'd2, 1'b0, 1'b1, sz, 1'b0, a, 32'h0, v, 5'd0, 1'b0);
  endtask

  task automatic ld(input logic [1:0] sz, input logic sx, input logic [31:0] a, input logic [4:0] r);
    issue(2'd2, 1'b1, 1'b0, sz, sx, a, 32'h0, 32'h0, r, 1'b1);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 128; i++) mdl[i] = 32'h0;
  endtask

  // Asynchronous reset pulse spanning one rising edge: outputs must clear at
  // once and nothing in flight may retire afterwards.
  task automatic pulse_reset();
    exp_t z;
    t_fu = 2'd0; t_rd = 1'b0; t_wr = 1'b0; t_wreg = 1'b0; t_rdst = 5'd0;
    reset = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("d%0d reset valid", dep_of(g)), 32'(o_vld[g]), 32'h0);
      check($sformatf("d%0d reset wbvalue", dep_of(g)), o_val[g], 32'h0);
      check($sformatf("d%0d reset regdest", dep_of(g)), 32'(o_rd[g]), 32'h0);
    end
    clear_model();
    z.vld = 1'b0; z.rd = 5'd0; z.wr = 1'b0; z.val = 32'h0; z.flt = 1'b0;
    for (int g = 0; g < 3; g++) begin
      sbq[g].delete();
      for (int k = 0; k <= dep_of(g); k++) begin
        z.due = cyc + k;
        sbq[g].push_back(z);
      end
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    clock = 1'b0;
    reset = 1'b0;
    t_fu = 2'd0; t_rd = 1'b0; t_wr = 1'b0; t_sz = 2'd0; t_sx = 1'b0;
    t_ra = 32'h0; t_imm = 32'h0; t_sv = 32'h0; t_rdst = 5'd0; t_wreg = 1'b0;
    clear_model();
    #1;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("d%0d init valid", dep_of(g)), 32'(o_vld[g]), 32'h0);
      check($sformatf("d%0d init wbvalue", dep_of(g)), o_val[g], 32'h0);
    end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;

    // Word store then back-to-back load of the same word.
    issue(2'd2, 1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h4, 32'hDEADBEEF, 5'd0, 1'b0);
    issue(2'd2, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h4, 32'h0, 5'd3, 1'b1);

    // Byte and half stores into word 8 with both extensions.
    st(2'd0, 32'h21, 32'h12345680);
    ld(2'd0, 1'b1, 32'h21, 5'd4);
    ld(2'd0, 1'b0, 32'h21, 5'd5);
    ld(2'd2, 1'b0, 32'h20, 5'd6);
    st(2'd1, 32'h22, 32'hAAAA8001);
    ld(2'd1, 1'b1, 32'h22, 5'd7);
    ld(2'd1, 1'b0, 32'h22, 5'd8);
    ld(2'd2, 1'b0, 32'h20, 5'd9);

    // Misaligned word store and half load.
    st(2'd2, 32'h22, 32'hFFFFFFFF);
    ld(2'd2, 1'b0, 32'h20, 5'd10);
    ld(2'd1, 1'b1, 32'h03, 5'd11);

    // Wrap-around and negative base.
    st(2'd2, 32'h204, 32'hCAFEF00D);
    ld(2'd2, 1'b0, 32'h004, 5'd12);
    issue(2'd2, 1'b1, 1'b0, 2'd3, 1'b0, 32'hFFFFFFFC, 32'h8, 32'h0, 5'd13, 1'b1);

    // Foreign unit code: bubbles, RAM untouched.
    issue(2'd1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 32'h0, 5'd14, 1'b1);
    issue(2'd1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h4, 32'h0, 32'h0, 5'd15, 1'b1);
    ld(2'd2, 1'b0, 32'h004, 5'd16);

    // Load and store flagged together: store wins, writereg passes through.
    issue(2'd2, 1'b1, 1'b1, 2'd2, 1'b0, 32'h30, 32'h0, 32'h13572468, 5'd17, 1'b1);
    ld(2'd2, 1'b0, 32'h30, 5'd18);
    bubble();

    // Mixed traffic over a handful of words.
    for (int n = 0; n < 24; n++) begin
      issue(($urandom_range(0, 4) == 0) ? 2'd1 : 2'd2, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'h40 + 32'($urandom_range(0, 15)), 32'($urandom_range(0, 3)), $urandom,
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    // Reset with loads in flight, then the first scenario again from cold.
    st(2'd2, 32'h50, 32'h89ABCDEF);
    for (int n = 0; n < 5; n++) ld(2'd2, 1'b0, 32'h50, 5'(20 + n));
    pulse_reset();
    ld(2'd2, 1'b0, 32'h14, 5'd3);
    issue(2'd2, 1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h4, 32'hDEADBEEF, 5'd0, 1'b0);
    issue(2'd2, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h4, 32'h0, 5'd3, 1'b1);
    ld(2'd2, 1'b0, 32'h50, 5'd19);

    repeat (8) bubble();
    repeat (8) @(posedge clock);
    @(negedge clock);
    #1;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("d%0d drained", dep_of(g)), 32'(sbq[g].size()), 32'h0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/execute_mem_pipe.md
# execute_mem_pipe

Parametrised load/store execution unit for the issue-driven pipeline. It is the next generation of the fixed four-stage memory unit. It accepts an instruction from issue when the functional-unit select matches `FU_ID`, computes a byte address, and performs a byte, half or word access with sign/zero extension on loads. It then carries the result through a configurable number of delay stages to writeback, flagging misaligned accesses instead of executing them.

## Interface
- `DATA_W`, 32: data width in bits; must be 32 in this generation, since size encodings assume 32.
- `ADDR_W`, 7: word-index width; memory is 2^ADDR_W words.
- `DEPTH`, 4: total stages from issue to writeback, minimum 2 (M0, M1, then DEPTH-2 delay stages).
- `FU_ID`, 2: functional-unit code this instance accepts.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low.
- `is_m0_functionalunit`  in  2: unit select; the slot is valid when it equals `FU_ID`.
- `is_m0_readmem`  in  1: load.
- `is_m0_writemem`  in  1: store.
- `is_m0_size`  in  2: 0 byte, 1 half, 2 word; 3 is treated as word.
- `is_m0_signext`  in  1: on loads, 1 sign-extends and 0 zero-extends.
- `is_m0_rega`  in  DATA_W: base address.
- `is_m0_imedext`  in  DATA_W: offset.
- `is_m0_regdestv`  in  DATA_W: store data, taken from the low bytes.
- `is_m0_regdest`  in  5: destination register.
- `is_m0_writereg`  in  1: register write request.
- `m_wb_valid`  out  1: a real instruction is in the writeback slot.
- `m_wb_regdest`  out  5: destination register.
- `m_wb_writereg`  out  1: register write enable.
- `m_wb_wbvalue`  out  DATA_W: load result, or 0.
- `m_wb_fault`  out  1: misaligned access retired.

## Operation
- Accept rule: the slot is valid only when `is_m0_functionalunit == FU_ID`. Otherwise M0 captures a bubble (all fields 0).
- M0 stage:
  - `addr = rega + imedext`, modulo 2^DATA_W.
  - Word index = `addr[ADDR_W+1:2]`, so the address wraps modulo memory size. Byte offset = `addr[1:0]`.
- Misalignment:
  - half with `addr[0]=1`, or word with `addr[1:0]!=0`.
  - A misaligned instruction has its store suppressed and its writereg forced to 0.
  - Its wbvalue is 0 and its fault bit is 1; valid is still 1.
- Loads and stores simultaneously set: the store is executed and the load is ignored; writereg passes unchanged.
- M1 store path:
  - Byte enables are derived from size and offset.
  - The low 8/16/32 bits of regdestv are placed at the byte lanes selected by the offset.
  - The RAM word is written at the rising edge ending the M1 cycle.
- M1 load path:
  - Asynchronous read of the indexed word.
  - The lane selected by the offset is extracted and then extended as selected by `is_m0_signext`.
  - The result is registered into the first delay stage.
- Non-load instructions carry wbvalue 0.
- Delay stages: DEPTH-2 register stages carrying valid, regdest, writereg, wbvalue and fault unchanged. When DEPTH=2, the M1 output register drives writeback directly.
- Every pipeline register, every output and the entire RAM reset to 0 while `reset` is low.

## Timing
- Latency: an instruction presented before rising edge k appears on the `m_wb_*` outputs after edge k+DEPTH-1.
- Throughput: one instruction per cycle, with no stall or backpressure.
- Store-to-load: a load whose M1 cycle immediately follows a store's M1 cycle to the same word reads the updated word. No forwarding logic is needed because the write lands at the edge between the two M1 cycles.
- Reset mid-operation:
  - Asserting reset clears all in-flight instructions immediately, with no completion.
  - A store in M1 at the moment of reset is lost.
  - After deassertion, the first accepted instruction retires exactly DEPTH edges later.

## Structure
- Package `mem_pkg`: size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`), the default `FU_ID` constant, and a stage-record struct (valid, regdest, writereg, wbvalue, fault) shared by the M1 and delay stages.
- Sub-module `mem_ram`: a 2^ADDR_W × 32 array with:
  - asynchronous read;
  - byte-enabled synchronous write;
  - asynchronous active-low clear.
- Delay stages are a generate loop in the top module.

## Test plan
- Word store then load:
  - Stimulus: store 0xDEADBEEF at rega=0x10, imm=4, followed by a word load to r3.
  - Required response: after DEPTH cycles, valid=1, regdest=3, wbvalue=0xDEADBEEF.
- Byte extension: store byte 0x80 at addr 0x21, then load it.
  - signext=1 load returns 0xFFFFFF80.
  - signext=0 load returns 0x00000080.
  - The other bytes of word 8 are unchanged.
- Misaligned access:
  - A word store at 0x22 sets fault=1 and leaves memory unchanged.
  - A half load at 0x03 gives fault=1, writereg=0, wbvalue=0.
- Wrap-around: for ADDR_W=7, an access at byte address 0x204 hits the same word as 0x004.
- Foreign unit and bubbles: with functionalunit=1 while readmem=1, valid=0 and writereg=0 at writeback, and the RAM is untouched.
- Reset and depth:
  - Pulse reset with three instructions in flight: all outputs become 0 at once and none retire.
  - Repeat the first scenario with DEPTH=2 and DEPTH=6; latency is 2 and 6 respectively.
